// File: rtl/fnd_pkg.sv
// Shared types and constants for the 4-digit FND scan driver:
// digit count, pin idle patterns, the display word and the hex-to-segment table.
package fnd_pkg;

  localparam int          FND_DIGITS  = 4;
  localparam logic [3:0]  FND_SEL_OFF = 4'b1111;
  localparam logic [7:0]  FND_BLANK   = 8'h00;

  typedef logic [1:0] digit_idx_t;

  // One complete display request as seen by the scanner.
  typedef struct packed {
    logic [15:0] data;
    logic [3:0]  dp;
    logic        blank_lz;
    logic        blink;
  } fnd_word_t;

  // Segment pattern {g,f,e,d,c,b,a}, active-high.
  function automatic logic [6:0] seg7(input logic [3:0] nibble);
    logic [6:0] seg;
    case (nibble)
      4'h0: seg = 7'h3F;
      4'h1: seg = 7'h06;
      4'h2: seg = 7'h5B;
      4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;
      4'h5: seg = 7'h6D;
      4'h6: seg = 7'h7D;
      4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h6F;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;
      4'hD: seg = 7'h5E;
      4'hE: seg = 7'h79;
      default: seg = 7'h71;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/fnd_hex_to_seg7.sv
// Combinational nibble + decimal point to 8-bit FND segment pattern {dp, g..a}.
module fnd_hex_to_seg7
  import fnd_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       dp,
  output logic [7:0] seg
);

  assign seg = {dp, seg7(nibble)};

endmodule

// File: rtl/fnd_scan_driver.sv
// 4-digit multiplexed 7-segment driver with load/ready handshake, anti-ghost guard,
// leading-zero blanking and whole-display blink; new words take effect at frame boundaries.
module fnd_scan_driver
  import fnd_pkg::*;
#(
  parameter int SCAN_DIV    = 13500,
  parameter int GUARD       = 16,
  parameter int BLINK_TICKS = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] data_in,
  input  logic [3:0]  dp_in,
  input  logic        blank_lz,
  input  logic        blink,
  output logic        ready,
  output logic        frame_done,
  output logic        fnd_en,
  output logic [3:0]  fnd_sel,
  output logic [7:0]  fnd_data
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BLK_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(SCAN_DIV - 1);
  localparam logic [DIV_W-1:0] GUARD_END  = DIV_W'(GUARD);
  localparam logic [BLK_W-1:0] BLINK_LAST = BLK_W'(BLINK_TICKS - 1);

  logic [DIV_W-1:0] div_cnt;
  digit_idx_t       digit_idx;
  logic [BLK_W-1:0] blink_cnt;
  logic             blink_on;
  fnd_word_t        shown, pending;

  logic slot_end, boundary, transfer, accept;

  assign slot_end = (div_cnt == DIV_LAST);
  assign boundary = slot_end && (digit_idx == digit_idx_t'(FND_DIGITS - 1));
  // Only a boundary with a word waiting moves it to the display.
  assign transfer = boundary && !ready;
  assign accept   = load && ready;

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt   <= '0;
      digit_idx <= '0;
    end else begin
      div_cnt <= slot_end ? '0 : div_cnt + 1'b1;
      if (slot_end) digit_idx <= digit_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shown   <= '0;
      pending <= '0;
      ready   <= 1'b1;
    end else begin
      if (transfer) begin
        shown <= pending;
        ready <= 1'b1;
      end
      if (accept) begin
        pending <= '{data: data_in, dp: dp_in, blank_lz: blank_lz, blink: blink};
        ready   <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      blink_cnt <= '0;
      blink_on  <= 1'b1;
    end else if (transfer || (slot_end && !shown.blink)) begin
      blink_cnt <= '0;
      blink_on  <= 1'b1;
    end else if (slot_end) begin
      if (blink_cnt == BLINK_LAST) begin
        blink_cnt <= '0;
        blink_on  <= !blink_on;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

  logic [3:0] cur_nibble;
  logic [7:0] cur_seg;
  logic [3:0] upper_zero;
  logic [3:0] sel_nxt;
  logic [7:0] data_nxt;

  assign cur_nibble = shown.data[{digit_idx, 2'b00} +: 4];

  fnd_hex_to_seg7 u_seg (
    .nibble (cur_nibble),
    .dp     (shown.dp[digit_idx]),
    .seg    (cur_seg)
  );

  // upper_zero[n]: nibbles n..3 are all zero; digit 0 is never blanked.
  always_comb begin
    upper_zero[3] = (shown.data[15:12] == 4'h0);
    upper_zero[2] = upper_zero[3] && (shown.data[11:8] == 4'h0);
    upper_zero[1] = upper_zero[2] && (shown.data[7:4] == 4'h0);
    upper_zero[0] = 1'b0;
  end

  // NOTE: defaults first so no path through this block can infer a latch.
  always_comb begin
    sel_nxt  = FND_SEL_OFF;
    data_nxt = FND_BLANK;
    if (div_cnt >= GUARD_END && blink_on) begin
      sel_nxt  = ~(4'b0001 << digit_idx);
      data_nxt = (shown.blank_lz && upper_zero[digit_idx]) ? {cur_seg[7], 7'h00} : cur_seg;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fnd_en     <= 1'b0;
      frame_done <= 1'b0;
      fnd_sel    <= FND_SEL_OFF;
      fnd_data   <= FND_BLANK;
    end else begin
      fnd_en     <= 1'b1;
      frame_done <= boundary;
      fnd_sel    <= sel_nxt;
      fnd_data   <= data_nxt;
    end
  end

endmodule

// File: tb/tb_fnd_scan_driver.sv
// Bench for fnd_scan_driver: a time-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized load traffic.
module tb_fnd_scan_driver;

  localparam int S  = 4;
  localparam int G  = 1;
  localparam int BT = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        load = 1'b0;
  logic [15:0] data_in = '0;
  logic [3:0]  dp_in = '0;
  logic        blank_lz = 1'b0;
  logic        blink = 1'b0;
  logic        ready, frame_done, fnd_en;
  logic [3:0]  fnd_sel;
  logic [7:0]  fnd_data;

  fnd_scan_driver #(.SCAN_DIV(S), .GUARD(G), .BLINK_TICKS(BT)) dut (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .data_in    (data_in),
    .dp_in      (dp_in),
    .blank_lz   (blank_lz),
    .blink      (blink),
    .ready      (ready),
    .frame_done (frame_done),
    .fnd_en     (fnd_en),
    .fnd_sel    (fnd_sel),
    .fnd_data   (fnd_data)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: position in the scan is derived purely from cycles since reset.
  logic [7:0]  seg_tbl [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                                8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};
  int          m_cyc = 0;
  int          m_xfer_slot = 0;
  bit          m_ready = 1'b1;
  logic [15:0] m_data = '0, p_data = '0;
  logic [3:0]  m_dp = '0, p_dp = '0;
  bit          m_blz = 1'b0, p_blz = 1'b0, m_blk = 1'b0, p_blk = 1'b0;
  logic        e_en = 1'b0, e_ready = 1'b1, e_fd = 1'b0;
  logic [3:0]  e_sel = 4'hF;
  logic [7:0]  e_data = 8'h00;

  always @(posedge clk or negedge reset) begin
    int  pos, slot, dig, nib;
    bit  on, blanked;
    if (!reset) begin
      m_cyc = 0; m_xfer_slot = 0; m_ready = 1'b1;
      m_data = '0; p_data = '0; m_dp = '0; p_dp = '0;
      m_blz = 1'b0; p_blz = 1'b0; m_blk = 1'b0; p_blk = 1'b0;
      e_en = 1'b0; e_ready = 1'b1; e_fd = 1'b0; e_sel = 4'hF; e_data = 8'h00;
    end else begin
      pos  = m_cyc % S;
      slot = m_cyc / S;
      dig  = slot % 4;
      on   = !m_blk || ((((slot - m_xfer_slot) / BT) % 2) == 0);
      e_en = 1'b1;
      e_fd = (pos == S - 1) && (dig == 3);
      if (pos < G || !on) begin
        e_sel  = 4'hF;
        e_data = 8'h00;
      end else begin
        nib     = int'((m_data >> (4 * dig)) & 16'h000F);
        blanked = m_blz && dig > 0 && ((m_data >> (4 * dig)) == 16'h0);
        e_sel   = 4'hF ^ (4'h1 << dig);
        e_data  = (blanked ? 8'h00 : (seg_tbl[nib] & 8'h7F)) | (m_dp[dig] ? 8'h80 : 8'h00);
      end
      if (e_fd && !m_ready) begin
        m_data = p_data; m_dp = p_dp; m_blz = p_blz; m_blk = p_blk;
        m_ready = 1'b1;
        m_xfer_slot = slot + 1;
      end else if (load && m_ready) begin
        p_data = data_in; p_dp = dp_in; p_blz = blank_lz; p_blk = blink;
        m_ready = 1'b0;
      end
      e_ready = m_ready;
      m_cyc++;
    end
  end

  always @(negedge clk) begin
    check("fnd_en", fnd_en, e_en);
    check("ready", ready, e_ready);
    check("frame_done", frame_done, e_fd);
    check("fnd_sel", fnd_sel, e_sel);
    check("fnd_data", fnd_data, e_data);
  end

  task automatic send(input logic [15:0] d, input logic [3:0] dp, input bit blz, input bit bl);
    @(negedge clk);
    data_in = d; dp_in = dp; blank_lz = blz; blink = bl; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic wait_ready(input int lim);
    int n = 0;
    while (ready !== 1'b1 && n < lim) begin
      @(negedge clk);
      n++;
    end
    check("ready_rise", ready, 1);
  endtask

  task automatic wait_sel(input logic [3:0] sel, input logic [7:0] d, input string name);
    int n = 0;
    @(negedge clk);
    while (fnd_sel !== sel && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({name, "_sel"}, fnd_sel, sel);
    check(name, fnd_data, d);
  endtask

  task automatic count_lit(input int cycles, output int lit);
    lit = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (fnd_sel != 4'hF) lit++;
    end
  endtask

  initial begin
    int lit;
    repeat (3) @(negedge clk);
    check("rst_en", fnd_en, 0);
    check("rst_sel", fnd_sel, 4'hF);
    check("rst_data", fnd_data, 8'h00);
    check("rst_ready", ready, 1);
    reset = 1'b1;
    @(negedge clk);
    check("en_after_release", fnd_en, 1);

    send(16'h1234, 4'b0001, 1'b0, 1'b0);
    check("ready_low_after_load", ready, 0);
    wait_ready(40);
    wait_sel(4'b1110, 8'hE6, "d0_1234");
    wait_sel(4'b0111, 8'h06, "d3_1234");

    send(16'h0005, 4'b0000, 1'b1, 1'b0);
    wait_ready(40);
    wait_sel(4'b1101, 8'h00, "lz_d1");
    wait_sel(4'b1011, 8'h00, "lz_d2");
    wait_sel(4'b0111, 8'h00, "lz_d3");
    wait_sel(4'b1110, 8'h6D, "lz_d0");

    send(16'hAAAA, 4'b0000, 1'b0, 1'b0);
    data_in = 16'hFFFF; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    check("ready_low_ignored", ready, 0);
    wait_ready(40);
    wait_sel(4'b1110, 8'h77, "a_d0");
    wait_sel(4'b1101, 8'h77, "a_d1");
    wait_sel(4'b1011, 8'h77, "a_d2");
    wait_sel(4'b0111, 8'h77, "a_d3");

    send(16'h8888, 4'b0000, 1'b0, 1'b1);
    wait_ready(40);
    count_lit(16, lit);
    check("blink_lit_frame1", lit, 6);
    count_lit(16, lit);
    check("blink_lit_frame2", lit, 6);

    for (int i = 0; i < 60; i++) begin
      logic [15:0] d;
      for (int k = 0; k < 4; k++)
        d[4*k +: 4] = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
      repeat ($urandom_range(0, 12)) @(negedge clk);
      data_in  = d;
      dp_in    = 4'($urandom_range(0, 15));
      blank_lz = 1'($urandom_range(0, 1));
      blink    = ($urandom_range(0, 3) == 0);
      load     = 1'b1;
      @(negedge clk);
      load     = 1'b0;
    end
    repeat (40) @(negedge clk);

    wait_ready(40);
    send(16'h9999, 4'b1111, 1'b0, 1'b0);
    check("ready_low_before_reset", ready, 0);
    @(posedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    check("midrst_en", fnd_en, 0);
    check("midrst_sel", fnd_sel, 4'hF);
    check("midrst_data", fnd_data, 8'h00);
    check("midrst_ready", ready, 1);
    @(negedge clk);
    reset = 1'b1;
    wait_sel(4'b1110, 8'h3F, "post_rst_d0");
    wait_sel(4'b0111, 8'h3F, "post_rst_d3");
    repeat (20) @(negedge clk);
    check("post_rst_ready", ready, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
